// File: rtl/signal_phase_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : signal_phase_ctrl_if
//  Brief    : Sensor input and lamp/phase outputs of the intersection sequencer
//  Revision : 1.0  initial release
// ============================================================================
interface signal_phase_ctrl_if;
    logic       b;
    logic       Ago;
    logic       Ayel;
    logic       Astop;
    logic       Bgo;
    logic       Byel;
    logic       Bstop;
    logic [2:0] phase;

    modport master (
        output b,
        input  Ago, Ayel, Astop, Bgo, Byel, Bstop, phase
    );

    modport slave (
        input  b,
        output Ago, Ayel, Astop, Bgo, Byel, Bstop, phase
    );
endinterface
`default_nettype wire

// File: rtl/signal_phase_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : signal_phase_ctrl
//  Brief    : Two-road phase sequencer; A rests green, B served on sensor demand
//  Revision : 1.0  initial release
// ============================================================================
module signal_phase_ctrl #(
    parameter int MIN_GREEN_A = 8,
    parameter int GREEN_B     = 4,
    parameter int MAX_GREEN_B = 8,
    parameter int YELLOW      = 2,
    parameter int ALL_RED     = 1,
    parameter int TW          = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    signal_phase_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        A_GRN = 3'd0,
        A_YEL = 3'd1,
        RED1  = 3'd2,
        B_GRN = 3'd3,
        B_YEL = 3'd4,
        RED2  = 3'd5
    } state_t;

    // Last timer value of each dwell: a dwell of N cycles exits at N-1
    localparam logic [TW-1:0] c_MIN_A_LAST = TW'(MIN_GREEN_A - 1);
    localparam logic [TW-1:0] c_GRN_B_LAST = TW'(GREEN_B - 1);
    localparam logic [TW-1:0] c_MAX_B_LAST = TW'(MAX_GREEN_B - 1);
    localparam logic [TW-1:0] c_YEL_LAST   = TW'(YELLOW - 1);
    localparam logic [TW-1:0] c_RED_LAST   = TW'(ALL_RED - 1);

    state_t          r_state;
    state_t          w_next;
    logic [TW-1:0]   r_timer;
    logic [TW-1:0]   w_timer_nxt;
    logic            r_pend;
    logic            w_pend_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= A_GRN;
            r_timer <= '0;
            r_pend  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_timer <= w_timer_nxt;
            r_pend  <= w_pend_nxt;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            A_GRN: if (r_timer == c_MIN_A_LAST && (r_pend || bus.b)) w_next = A_YEL;
            A_YEL: if (r_timer == c_YEL_LAST) w_next = RED1;
            RED1:  if (r_timer == c_RED_LAST) w_next = B_GRN;
            B_GRN: if ((r_timer >= c_GRN_B_LAST && !bus.b) || r_timer == c_MAX_B_LAST)
                       w_next = B_YEL;
            B_YEL: if (r_timer == c_YEL_LAST) w_next = RED2;
            RED2:  if (r_timer == c_RED_LAST) w_next = A_GRN;
            default: w_next = A_GRN;
        endcase
    end

    // A_GRN parks at its minimum so a late request leaves immediately
    always_comb begin
        w_timer_nxt = r_timer + 1'b1;
        if (w_next != r_state) begin
            w_timer_nxt = '0;
        end else if (r_state == A_GRN && r_timer == c_MIN_A_LAST) begin
            w_timer_nxt = r_timer;
        end
    end

    // Entering B_GRN serves any latched demand, so clearing wins over setting
    always_comb begin
        w_pend_nxt = r_pend;
        if (w_next == B_GRN && r_state != B_GRN) begin
            w_pend_nxt = 1'b0;
        end else if (bus.b && r_state != B_GRN) begin
            w_pend_nxt = 1'b1;
        end
    end

    always_comb begin
        bus.Ago   = 1'b0;
        bus.Ayel  = 1'b0;
        bus.Astop = 1'b1;
        bus.Bgo   = 1'b0;
        bus.Byel  = 1'b0;
        bus.Bstop = 1'b1;
        bus.phase = r_state;
        case (r_state)
            A_GRN: begin bus.Ago  = 1'b1; bus.Astop = 1'b0; end
            A_YEL: begin bus.Ayel = 1'b1; bus.Astop = 1'b0; end
            B_GRN: begin bus.Bgo  = 1'b1; bus.Bstop = 1'b0; end
            B_YEL: begin bus.Byel = 1'b1; bus.Bstop = 1'b0; end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_signal_phase_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_signal_phase_ctrl
//  Brief    : Directed and random-sensor bench for signal_phase_ctrl
//  Revision : 1.0  initial release
// ============================================================================
module tb_signal_phase_ctrl;

    localparam int c_MAX_LAT = 14;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    signal_phase_ctrl_if bus ();

    signal_phase_ctrl u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] lamps_for(input logic [2:0] ph);
        case (ph)
            3'd0:    return 6'b100_001;
            3'd1:    return 6'b010_001;
            3'd3:    return 6'b001_100;
            3'd4:    return 6'b001_010;
            default: return 6'b001_001;
        endcase
    endfunction

    function automatic logic [5:0] lamps_now();
        return {bus.Ago, bus.Ayel, bus.Astop, bus.Bgo, bus.Byel, bus.Bstop};
    endfunction

    function automatic logic b_of(input int t, input int c);
        case (t)
            2:       return (c == 2);
            3:       return (c == 20);
            4:       return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] exp_phase(input int t, input int c);
        case (t)
            2: begin
                if (c <= 7)  return 3'd0;
                if (c <= 9)  return 3'd1;
                if (c == 10) return 3'd2;
                if (c <= 14) return 3'd3;
                if (c <= 16) return 3'd4;
                if (c == 17) return 3'd5;
                return 3'd0;
            end
            3: begin
                if (c <= 20) return 3'd0;
                if (c <= 22) return 3'd1;
                if (c == 23) return 3'd2;
                if (c <= 27) return 3'd3;
                if (c <= 29) return 3'd4;
                if (c == 30) return 3'd5;
                return 3'd0;
            end
            4: begin
                if (c <= 7)  return 3'd0;
                if (c <= 9)  return 3'd1;
                if (c == 10) return 3'd2;
                if (c <= 18) return 3'd3;
                if (c <= 20) return 3'd4;
                if (c == 21) return 3'd5;
                if (c <= 29) return 3'd0;
                if (c <= 31) return 3'd1;
                if (c == 32) return 3'd2;
                return 3'd3;
            end
            default: return 3'd0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Two reset cycles; on return the bench sits in cycle 0
    task automatic apply_reset();
        rst   = 1'b1;
        bus.b = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic check_cycle(input string tag, input logic [2:0] exp_ph);
        checks++;
        assert (bus.phase === exp_ph) else begin
            errors++;
            $error("FAIL %s phase cyc %0d got %0d exp %0d", tag, cyc, bus.phase, exp_ph);
        end
        checks++;
        assert (lamps_now() === lamps_for(exp_ph)) else begin
            errors++;
            $error("FAIL %s lamps cyc %0d got %b exp %b", tag, cyc, lamps_now(), lamps_for(exp_ph));
        end
    endtask

    task automatic run_test(input string tag, input int t, input int ncyc);
        apply_reset();
        for (int c = 0; c < ncyc; c++) begin
            bus.b = b_of(t, c);
            check_cycle(tag, exp_phase(t, c));
            tick();
        end
        bus.b = 1'b0;
    endtask

    initial begin
        logic       waiting;
        int         age;
        logic [5:0] lv;

        run_test("T1_idle",   1, 30);
        run_test("T2_pulse",  2, 40);
        run_test("T3_late",   3, 45);
        run_test("T4_held",   4, 34);

        // T5: reset lands in cycle 13 while B is green and demand is present
        apply_reset();
        bus.b = 1'b1;
        while (cyc < 13) tick();
        check_cycle("T5_pre", 3'd3);
        rst = 1'b1;
        tick();
        rst   = 1'b0;
        bus.b = 1'b0;
        for (int c = 14; c < 34; c++) begin
            check_cycle("T5_post", 3'd0);
            tick();
        end

        // T6: random sensor; lamp sanity each cycle and bounded service latency
        apply_reset();
        waiting = 1'b0;
        age     = 0;
        for (int c = 0; c < 5000; c++) begin
            lv = lamps_now();
            checks++;
            assert ($onehot(lv[5:3]) && $onehot(lv[2:0]) && !(bus.Ago && bus.Bgo)
                    && !(bus.Ayel && bus.Byel) && bus.phase <= 3'd5
                    && lv === lamps_for(bus.phase)) else begin
                errors++;
                $error("FAIL T6_lamps cyc %0d got %b/%0d exp decode %b", cyc, lv, bus.phase,
                       lamps_for(bus.phase));
            end
            if (waiting) begin
                checks++;
                assert (age <= c_MAX_LAT) else begin
                    errors++;
                    $error("FAIL T6_latency cyc %0d got %0d exp <=%0d", cyc, age, c_MAX_LAT);
                    waiting = 1'b0;
                end
                if (bus.phase == 3'd3) waiting = 1'b0;
            end
            bus.b = ($urandom_range(9, 0) == 0);
            if (bus.b && bus.phase != 3'd3 && !waiting) begin
                waiting = 1'b1;
                age     = 0;
            end
            tick();
            age++;
        end
        bus.b = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
